// File: rtl/udma_i2s_pkg.sv
// -----------------------------------------------------------------------------
// udma_i2s_pkg
// Shared definitions for the I2S RX arbiter slice.
//   i2s_arb_mode_e : arbitration mode encoding (matches cfg_mode_i)
//   I2S_ARB_NCH    : number of arbitrated I2S channels
// -----------------------------------------------------------------------------
package udma_i2s_pkg;

    typedef enum logic [1:0] {
        ARB_RR     = 2'b00,
        ARB_PRIO0  = 2'b01,
        ARB_ALT    = 2'b10,
        ARB_SINGLE = 2'b11
    } i2s_arb_mode_e;

    localparam int I2S_ARB_NCH = 2;

endpackage

// File: rtl/udma_i2s_rx_arb_if.sv
// -----------------------------------------------------------------------------
// udma_i2s_rx_arb_if
// Bundles the configuration, both channel streams, the uDMA RX stream and the
// status outputs of udma_i2s_rx_arb.
//   slave  : arbiter side (consumes channels, produces the RX stream)
//   master : environment side (drives config/channels, sinks the RX stream)
// -----------------------------------------------------------------------------
interface udma_i2s_rx_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  cfg_en_i;
    logic                  cfg_clr_i;
    logic [1:0]            cfg_mode_i;
    logic                  cfg_single_ch_i;
    logic [DATA_WIDTH-1:0] ch0_data_i;
    logic                  ch0_valid_i;
    logic                  ch0_ready_o;
    logic [DATA_WIDTH-1:0] ch1_data_i;
    logic                  ch1_valid_i;
    logic                  ch1_ready_o;
    logic [DATA_WIDTH-1:0] data_rx_o;
    logic                  data_rx_valid_o;
    logic                  data_rx_ready_i;
    logic [CNT_WIDTH-1:0]  cnt_ch0_o;
    logic [CNT_WIDTH-1:0]  cnt_ch1_o;
    logic                  alt_wait_o;

    modport slave (
        input  cfg_en_i, cfg_clr_i, cfg_mode_i, cfg_single_ch_i,
        input  ch0_data_i, ch0_valid_i, ch1_data_i, ch1_valid_i,
        input  data_rx_ready_i,
        output ch0_ready_o, ch1_ready_o,
        output data_rx_o, data_rx_valid_o,
        output cnt_ch0_o, cnt_ch1_o, alt_wait_o
    );

    modport master (
        output cfg_en_i, cfg_clr_i, cfg_mode_i, cfg_single_ch_i,
        output ch0_data_i, ch0_valid_i, ch1_data_i, ch1_valid_i,
        output data_rx_ready_i,
        input  ch0_ready_o, ch1_ready_o,
        input  data_rx_o, data_rx_valid_o,
        input  cnt_ch0_o, cnt_ch1_o, alt_wait_o
    );
endinterface

// File: rtl/udma_i2s_arb_oreg.sv
// -----------------------------------------------------------------------------
// udma_i2s_arb_oreg
// Single-entry output register of the RX arbiter.
//   i_clk, i_srst : clock, synchronous active-high reset
//   i_clr         : synchronous flush (drops the held word)
//   i_load        : load i_data (only asserted by the top while o_free is high)
//   i_data        : word to load
//   i_ready       : downstream ready
//   o_data/o_valid: registered output word
//   o_free        : register can accept a word this cycle
// -----------------------------------------------------------------------------
module udma_i2s_arb_oreg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_srst,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_free
);
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    assign o_free  = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clr) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            // Word consumed with nothing to replace it; data is left as-is.
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/udma_i2s_rx_arb.sv
// -----------------------------------------------------------------------------
// udma_i2s_rx_arb
// Merges the I2S channel-0 and channel-1 sample streams into the single uDMA
// RX stream. Modes: round-robin, channel-0 priority, strict alternation and
// single-channel. Keeps a grant counter per channel.
//   sys_clk_i : system clock
//   rst_i     : synchronous active-high reset
//   bus       : udma_i2s_rx_arb_if.slave (config, channel streams, RX stream,
//               counters, alt_wait_o)
// Optional build macro I2S_RX_ARB_TAG_EN: bit DATA_WIDTH-1 of data_rx_o is
// replaced by the granting channel id so the uDMA can deinterleave.
// -----------------------------------------------------------------------------
module udma_i2s_rx_arb
    import udma_i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               sys_clk_i,
    input  logic               rst_i,
    udma_i2s_rx_arb_if.slave   bus
);
    logic [I2S_ARB_NCH-1:0] w_valid;
    logic [I2S_ARB_NCH-1:0] w_ready;
    logic                   w_free;
    logic                   w_can_gnt;
    logic                   w_gnt_vld;
    logic                   w_gnt_ch;
    logic [DATA_WIDTH-1:0]  w_gnt_data;
    i2s_arb_mode_e          r_mode;
    logic                   r_last_gnt;
    logic                   r_exp;

    assign w_valid   = {bus.ch1_valid_i, bus.ch0_valid_i};
    assign w_can_gnt = !rst_i && !bus.cfg_clr_i && bus.cfg_en_i && w_free;

    // Grant selection; r_mode is the mode sampled last cycle, so a new
    // cfg_mode_i value steers the grant from the following cycle on.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = 1'b0;
        if (w_can_gnt) begin
            case (r_mode)
                ARB_RR: begin
                    if (&w_valid) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_ch  = ~r_last_gnt;
                    end else if (w_valid[0]) begin
                        w_gnt_vld = 1'b1;
                    end else if (w_valid[1]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_ch  = 1'b1;
                    end
                end
                ARB_PRIO0: begin
                    if (w_valid[0]) begin
                        w_gnt_vld = 1'b1;
                    end else if (w_valid[1]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_ch  = 1'b1;
                    end
                end
                ARB_ALT: begin
                    w_gnt_vld = w_valid[r_exp];
                    w_gnt_ch  = r_exp;
                end
                ARB_SINGLE: begin
                    w_gnt_vld = w_valid[bus.cfg_single_ch_i];
                    w_gnt_ch  = bus.cfg_single_ch_i;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_gnt_data = w_gnt_ch ? bus.ch1_data_i : bus.ch0_data_i;
`ifdef I2S_RX_ARB_TAG_EN
        w_gnt_data[DATA_WIDTH-1] = w_gnt_ch;
`endif
    end

    // Per-channel ready and grant counter. A ready is only raised for a
    // valid channel, so ready alone marks a transfer.
    genvar gi;
    generate
        for (gi = 0; gi < I2S_ARB_NCH; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] r_cnt;

            assign w_ready[gi] = w_gnt_vld && (w_gnt_ch == 1'(gi));

            always_ff @(posedge sys_clk_i) begin
                if (rst_i || bus.cfg_clr_i) begin
                    r_cnt <= '0;
                end else if (w_ready[gi]) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.ch0_ready_o = w_ready[0];
    assign bus.ch1_ready_o = w_ready[1];
    assign bus.cnt_ch0_o   = g_ch[0].r_cnt;
    assign bus.cnt_ch1_o   = g_ch[1].r_cnt;
    assign bus.alt_wait_o  = !rst_i && (r_mode == ARB_ALT) && w_free && bus.cfg_en_i
                             && !w_valid[r_exp] && w_valid[~r_exp];

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_mode <= ARB_RR;
        end else begin
            r_mode <= i2s_arb_mode_e'(bus.cfg_mode_i);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i || bus.cfg_clr_i) begin
            r_last_gnt <= 1'b1;
            r_exp      <= 1'b0;
        end else begin
            if (w_gnt_vld) begin
                r_last_gnt <= w_gnt_ch;
            end
            // Entering ALT always restarts the alternation at channel 0.
            if ((i2s_arb_mode_e'(bus.cfg_mode_i) == ARB_ALT) && (r_mode != ARB_ALT)) begin
                r_exp <= 1'b0;
            end else if (w_gnt_vld && (r_mode == ARB_ALT)) begin
                r_exp <= ~r_exp;
            end
        end
    end

    udma_i2s_arb_oreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_oreg (
        .i_clk   (sys_clk_i),
        .i_srst  (rst_i),
        .i_clr   (bus.cfg_clr_i),
        .i_load  (w_gnt_vld),
        .i_data  (w_gnt_data),
        .i_ready (bus.data_rx_ready_i),
        .o_data  (bus.data_rx_o),
        .o_valid (bus.data_rx_valid_o),
        .o_free  (w_free)
    );
endmodule

// File: doc/udma_i2s_rx_arb.md
# udma_i2s_rx_arb

Two-requester arbiter and scheduler that merges the I2S slave channel-0 and channel-1 sample streams into the single uDMA RX stream, in the sys_clk_i domain. It sits between the RX dual-clock FIFO outputs and the uDMA RX channel port (data_rx_o / valid / ready). It supports round-robin, fixed-priority, strict L/R alternation and single-channel modes, plus per-channel grant counters.

## Interface
- DATA_WIDTH, 32, sample word width.
- CNT_WIDTH, 16, width of each per-channel grant counter.

Ports. One clock; reset is synchronous and active-high.
- sys_clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_en_i  in  1  arbiter enable; when low, no new grants are issued.
- cfg_clr_i  in  1  single-cycle synchronous flush.
- cfg_mode_i  in  2  arbitration mode: 00 RR, 01 PRIO0, 10 ALT, 11 SINGLE.
- cfg_single_ch_i  in  1  channel used in SINGLE mode.
- ch0_data_i  in  DATA_WIDTH  channel 0 sample.
- ch0_valid_i  in  1  channel 0 valid.
- ch0_ready_o  out  1  channel 0 ready.
- ch1_data_i, ch1_valid_i, ch1_ready_o: same as channel 0, for channel 1.
- data_rx_o  out  DATA_WIDTH  registered output sample.
- data_rx_valid_o  out  1  output valid.
- data_rx_ready_i  in  1  uDMA ready.
- cnt_ch0_o, cnt_ch1_o  out  CNT_WIDTH  accepted-sample counters.
- alt_wait_o  out  1  ALT mode is stalled waiting for the expected channel.

## Operation
- Output register: a single entry. It is free when `!data_rx_valid_o || data_rx_ready_i`.
- Grant is computed combinationally from the valids, the mode and the pointer state. The grant is issued only when cfg_en_i is high and the output register is free.
- chN_ready_o = grant==N. At most one ready is high per cycle.
- A transfer on channel N (chN_valid_i && chN_ready_o) loads data_rx_o, sets valid and increments cnt_chN_o.
- Counters wrap modulo 2^CNT_WIDTH.
- RR mode:
  - last_gnt pointer, reset value 1, so channel 0 wins first.
  - When both channels are valid, the channel ≠ last_gnt wins.
  - When one channel is valid, it wins.
  - last_gnt updates on every transfer.
- PRIO0 mode: channel 0 always wins when valid; channel 1 is granted only when ch0_valid_i is low.
- ALT mode:
  - exp pointer, reset value 0. Only channel exp may be granted.
  - exp toggles after each transfer.
  - A valid on the other channel is held: its ready stays low and it is not dropped.
  - alt_wait_o = free && cfg_en_i && !valid[exp] && valid[!exp].
- SINGLE mode: only cfg_single_ch_i is granted. The other channel's ready is held low.
- Mode change: takes effect from the next cycle's grant. When cfg_mode_i changes into ALT, exp is forced to 0.
- cfg_clr_i:
  - data_rx_valid_o←0, data_rx_o←0, counters←0, last_gnt←1, exp←0.
  - No grant is issued in that cycle; cfg_clr_i overrides a simultaneous transfer.
- cfg_en_i low: grants stop, but a held output word still drains through data_rx_ready_i.
- Reset values: data_rx_o=0, data_rx_valid_o=0, cnt_ch0_o=cnt_ch1_o=0, alt_wait_o=0. ch0_ready_o and ch1_ready_o are 0 while rst_i is high.

## Timing
- Latency: one cycle from input handshake to data_rx_valid_o.
- Full throughput: one word per cycle when data_rx_ready_i is held high.
- The output is stable while `data_rx_valid_o && !data_rx_ready_i`; data_rx_o does not change.
- Readies depend combinationally on data_rx_ready_i. There is no combinational path from any input to data_rx_o.
- Counter outputs are registered and update in the cycle after the handshake.
- Reset or clear mid-transfer: a pending output word is discarded. Upstream words not yet handshaken are unaffected.

## Configuration
- I2S_RX_ARB_TAG_EN, when defined: bit DATA_WIDTH-1 of data_rx_o carries the granting channel id. The sample MSB is overwritten; the uDMA sees the tag for deinterleaving.
- Without the macro: samples pass through unmodified.

## Structure
- Shared package udma_i2s_pkg:
  - typedef enum logic [1:0] i2s_arb_mode_e with values ARB_RR, ARB_PRIO0, ARB_ALT, ARB_SINGLE.
  - Constant I2S_ARB_NCH = 2.
- One sub-module, udma_i2s_arb_oreg: the single-entry output register with the free/load/hold logic and flush. Grant logic, pointers and counters stay in the top.

## Test plan
- RR, both channels valid continuously, ready=1:
  - Output alternates ch0,ch1,ch0, …
  - After 8 cycles, cnt_ch0=4 and cnt_ch1=4.
- PRIO0, both valid for 5 cycles, then ch0 drops:
  - The first 5 outputs are ch0.
  - ch1 data appears on the following cycle.
- ALT, ch1 valid alone with data 0xB1:
  - ch1_ready_o=0 and alt_wait_o=1.
  - ch0 valid with 0xA0 is sent, then 0xB1, in that order.
- Backpressure: data_rx_ready_i=0 for 3 cycles with output 0x1234 held.
  - data_rx_o remains 0x1234.
  - Both readies stay 0.
  - Counters stay unchanged.
- cfg_clr_i pulse while output valid with cnt_ch0=7:
  - Next cycle, valid=0 and cnt_ch0=0.
  - In RR mode, the next grant goes to ch0.
- Built with I2S_RX_ARB_TAG_EN, SINGLE mode with cfg_single_ch_i=1, input 0x0000_0055:
  - Output is 0x8000_0055.
  - ch0_ready_o stays 0.
